// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
//   Immediate-extension unit between decode and execute. It widens an IN_W-bit
//   immediate to OUT_W bits according to a 2-bit mode, then carries the result
//   through a STAGES-deep register pipeline. Each stage holds a valid tag and
//   the mode alongside the data. The pipeline supports stall and flush.
//
//   Mode | extension
//   00   | sign-extend
//   01   | zero-extend
//   10   | upper: IN in the top IN_W bits, lower bits zero
//   11   | branch offset: sign-extend, then shift left by 2
//
// Ports
//   Clk      in   rising-edge clock
//   Rst      in   synchronous reset, active-high, clears every stage
//   Stall    in   hold every stage; the input in that cycle is dropped
//   Flush    in   clear every stage; overrides Stall
//   InValid  in   IN/Mode carry a real instruction this cycle
//   Mode     in   [1:0] extension mode
//   IN       in   [IN_W-1:0] raw immediate
//   OUT      out  [OUT_W-1:0] extended immediate from the last stage
//   OutValid out  OUT holds a valid result
//   OutMode  out  [1:0] mode travelling with OUT
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             InValid,
    input  logic [1:0]       Mode,
    input  logic [IN_W-1:0]  IN,
    output logic [OUT_W-1:0] OUT,
    output logic             OutValid,
    output logic [1:0]       OutMode
);

    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] upper;
    logic [OUT_W-1:0] branch;

    logic             valid_d;
    logic [1:0]       mode_d;
    logic [OUT_W-1:0] data_d;

    logic             valid_q [STAGES];
    logic [1:0]       mode_q  [STAGES];
    logic [OUT_W-1:0] data_q  [STAGES];

    assign sext   = {{EXT_W{IN[IN_W-1]}}, IN};
    assign zext   = {{EXT_W{1'b0}}, IN};
    assign upper  = {IN, {EXT_W{1'b0}}};
    // Top two bits of the sign-extended value fall off the end.
    assign branch = {sext[OUT_W-3:0], 2'b00};

    // A bubble carries zero data and mode 00, so an X on Mode while InValid
    // is low never reaches the stage registers.
    always_comb begin
        valid_d = InValid;
        mode_d  = 2'b00;
        data_d  = '0;
        if (InValid) begin
            mode_d = Mode;
            case (Mode)
                2'b00:   data_d = sext;
                2'b01:   data_d = zext;
                2'b10:   data_d = upper;
                default: data_d = branch;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                mode_q[k]  <= 2'b00;
                data_q[k]  <= '0;
            end
        end else if (!Stall) begin
            valid_q[0] <= valid_d;
            mode_q[0]  <= mode_d;
            data_q[0]  <= data_d;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                mode_q[k]  <= mode_q[k-1];
                data_q[k]  <= data_q[k-1];
            end
        end
    end

    assign OUT      = data_q[STAGES-1];
    assign OutValid = valid_q[STAGES-1];
    assign OutMode  = mode_q[STAGES-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush, InValid;
    logic [1:0]  Mode;
    logic [15:0] IN;

    logic [31:0] out2, out4;
    logic        ov2, ov4;
    logic [1:0]  om2, om4;

    always #5 Clk = ~Clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
        .Mode(Mode), .IN(IN), .OUT(out2), .OutValid(ov2), .OutMode(om2));

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
        .Mode(Mode), .IN(IN), .OUT(out4), .OutValid(ov4), .OutMode(om4));

    typedef struct {
        longint      due;
        logic        v;
        logic [1:0]  mode;
        logic [31:0] data;
    } exp_t;

    localparam int DEPTH [2] = '{2, 4};

    exp_t   sb [2][$];
    exp_t   prev [2];
    int     compared   = 0;
    int     mismatched = 0;
    longint shift_n    = 0;
    int     last_kind  = 0;   // 0 = cleared, 1 = held, 2 = shifted
    bit     started    = 0;

    // Reference extension using plain integer arithmetic.
    function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] x);
        longint s;
        longint r;
        s = (x >= 16'h8000) ? longint'(x) - 65536 : longint'(x);
        case (m)
            2'd0:    r = s;
            2'd1:    r = longint'(x);
            2'd2:    r = longint'(x) * 65536;
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    task automatic step(input logic rst, input logic fl, input logic st,
                        input logic iv, input logic [1:0] m, input logic [15:0] x);
        exp_t e;
        Rst = rst; Flush = fl; Stall = st; InValid = iv; Mode = m; IN = x;
        @(posedge Clk);
        if (rst || fl) begin
            sb[0].delete();
            sb[1].delete();
            last_kind = 0;
        end else if (st) begin
            last_kind = 1;
        end else begin
            shift_n++;
            last_kind = 2;
            if (iv) begin
                for (int d = 0; d < 2; d++) begin
                    e.due  = shift_n + DEPTH[d] - 1;
                    e.v    = 1'b1;
                    e.mode = m;
                    e.data = ref_ext(m, x);
                    sb[d].push_back(e);
                end
            end
        end
        started = 1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'bxx, 16'h0);
    endtask

    task automatic cmp(input int d, input logic v, input logic [31:0] o, input logic [1:0] om);
        exp_t e;
        e.due = 0; e.v = 0; e.mode = 0; e.data = 0;
        if (last_kind == 1) begin
            e = prev[d];
        end else if (last_kind == 2) begin
            while (sb[d].size() > 0 && sb[d][0].due < shift_n) begin
                compared++; mismatched++;
                $display("FAIL lost_entry dut%0d: entry due at shift %0d never seen (now %0d)",
                         DEPTH[d], sb[d][0].due, shift_n);
                void'(sb[d].pop_front());
            end
            if (sb[d].size() > 0 && sb[d][0].due == shift_n) e = sb[d].pop_front();
        end
        compared++;
        if (v !== e.v || o !== e.data || om !== e.mode) begin
            mismatched++;
            $display("FAIL out_check dut%0d t=%0t: got v=%b out=%08h mode=%b, want v=%b out=%08h mode=%b",
                     DEPTH[d], $time, v, o, om, e.v, e.data, e.mode);
        end
        prev[d] = e;
    endtask

    // Monitor: checks both pipelines once per cycle, away from the clock edge.
    always @(negedge Clk) begin
        if (started) begin
            cmp(0, ov2, out2, om2);
            cmp(1, ov4, out4, om4);
        end
    end

    initial begin
        Rst = 1; Flush = 0; Stall = 0; InValid = 0; Mode = 0; IN = 0;
        // Reset, then idle
        step(1, 0, 0, 0, 2'b00, 16'h0);
        step(1, 0, 0, 0, 2'b00, 16'h0);
        idle(4);

        // Mixed modes back to back
        step(0, 0, 0, 1, 2'b00, 16'h8000);
        step(0, 0, 0, 1, 2'b01, 16'h8000);
        step(0, 0, 0, 1, 2'b10, 16'h1234);
        idle(4);

        // Branch offsets
        step(0, 0, 0, 1, 2'b11, 16'hFFFE);
        step(0, 0, 0, 1, 2'b11, 16'h0003);
        step(0, 0, 0, 1, 2'b11, 16'h7FFF);
        idle(4);

        // Stall for 3 cycles after the first entry; dropped input is re-presented
        step(0, 0, 0, 1, 2'b01, 16'h0001);
        step(0, 0, 1, 1, 2'b01, 16'h0002);
        step(0, 0, 1, 1, 2'b01, 16'h0002);
        step(0, 0, 1, 1, 2'b01, 16'h0002);
        step(0, 0, 0, 1, 2'b01, 16'h0002);
        step(0, 0, 0, 1, 2'b01, 16'h0003);
        idle(5);

        // Flush together with stall, two entries in flight
        step(0, 0, 0, 1, 2'b00, 16'hABCD);
        step(0, 0, 0, 1, 2'b10, 16'h5555);
        step(0, 1, 1, 1, 2'b01, 16'h7777);
        idle(5);

        // Reset mid-stream with 4 valid entries in flight, then a fresh entry
        step(0, 0, 0, 1, 2'b00, 16'h1111);
        step(0, 0, 0, 1, 2'b01, 16'h2222);
        step(0, 0, 0, 1, 2'b10, 16'h3333);
        step(0, 0, 0, 1, 2'b11, 16'h4444);
        step(1, 0, 0, 0, 2'b00, 16'h0);
        idle(4);
        step(0, 0, 0, 1, 2'b00, 16'h00FF);
        idle(5);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic r, f, s, v;
            logic [1:0] m;
            r = ($urandom_range(99) < 2);
            f = ($urandom_range(99) < 3);
            s = ($urandom_range(99) < 15);
            v = ($urandom_range(99) < 70);
            m = 2'($urandom_range(3));
            step(r, f, s, v, m, 16'($urandom));
        end
        idle(6);
        @(negedge Clk);
        #1;

        for (int d = 0; d < 2; d++) begin
            compared++;
            if (sb[d].size() != 0) begin
                mismatched++;
                $display("FAIL drain dut%0d: %0d entries still expected, want 0", DEPTH[d], sb[d].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised immediate-extension unit for the pipelined datapath; replaces the fixed 16-to-32 sign extender.
- Accepts an IN_W-bit instruction immediate and a 2-bit extension mode.
- Produces an OUT_W-bit operand through a STAGES-deep register pipeline with valid tagging, stall and flush. It sits between decode and execute.

Parameters:
- IN_W, 16, immediate input width; legal range 2..OUT_W-2.
- OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W+2.
- STAGES, 1, pipeline depth (register stages) from IN to OUT; legal range 1..4.

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous reset, active-high
- Stall  input  1  hold all stages when high
- Flush  input  1  invalidate all stages when high
- InValid  input  1  IN/Mode carry a real instruction this cycle
- Mode  input  2  extension mode (see Behaviour)
- IN  input  IN_W  raw immediate field
- OUT  output  OUT_W  extended immediate from final stage
- OutValid  output  1  OUT holds a valid result
- OutMode  output  2  Mode value travelling with OUT

Behaviour:
- Extension function, combinational ahead of stage 1, where S = IN[IN_W-1]:
  - Mode 00, sign-extend: OUT_W-IN_W copies of S, then IN.
  - Mode 01, zero-extend: OUT_W-IN_W zeros, then IN.
  - Mode 10, upper: IN placed in OUT[OUT_W-1 : OUT_W-IN_W]; lower bits zero.
  - Mode 11, branch offset: sign-extend, then shift left 2. Bits shifted out at the top are discarded; the two LSBs are 0.
- Pipeline: STAGES registers, each holding {valid, mode, data}. Stage 1 loads {InValid, Mode, ext(IN,Mode)}. Stage k loads stage k-1. OUT, OutValid and OutMode come directly from the last stage.
- Latency is exactly STAGES cycles from the input edge to OUT when Stall stays low. There are no combinational paths from inputs to outputs.
- Bubble rule: a stage loaded with valid=0 writes data=0 and mode=00. OUT is therefore 0 whenever OutValid=0.
- Priority at each rising edge, highest first:
  - Rst: every stage is cleared to valid=0, data=0, mode=00. OUT=0, OutValid=0 and OutMode=00 on the cycle after Rst is sampled high. This applies mid-stream; all in-flight entries are lost.
  - Flush: every stage is cleared exactly as for Rst. This holds even if Stall is also high (flush beats stall). The input presented in the same cycle is dropped.
  - Stall: every stage holds its contents. The input presented in the same cycle is dropped; the upstream stage must re-present it.
  - Otherwise: the pipeline shifts by one stage.
- No internal state beyond the stage registers: no FSM, no counters. Throughput is 1 result per cycle when not stalled.
- Stall held for N cycles holds OUT/OutValid constant for N cycles, then resumes with the held values in order.
- Back-to-back valid inputs with mixed modes each emerge unaltered, in order, with the correct OutMode.
- Undriven or X Mode while InValid=0 must not propagate X: the bubble rule forces zero data and mode 00.

Test Plan (IN_W=16, OUT_W=32, STAGES=2 unless noted):
- Rst high 2 cycles, then low, with idle inputs -> OUT=0x00000000, OutValid=0, OutMode=00 throughout.
- Cycle 0: IN=0x8000, Mode=00, InValid=1. Cycle 1: IN=0x8000, Mode=01. Cycle 2: IN=0x1234, Mode=10 -> OUT=0xFFFF8000 at cycle 2, 0x00008000 at cycle 3, 0x12340000 at cycle 4, OutValid=1 each cycle with matching OutMode.
- Mode=11 with IN=0xFFFE, then IN=0x0003, then IN=0x7FFF -> OUT=0xFFFFFFF8, then 0x0000000C, then 0x0001FFFC.
- Stream 0x0001, 0x0002, 0x0003 (Mode 01) with Stall high for 3 cycles after the first enters -> OUT holds its value during the stall, no entry is lost or duplicated among those presented while not stalled, order is preserved.
- Flush asserted together with Stall while 2 valid entries are in flight -> next cycle OutValid=0 and OUT=0. The entry presented with Flush never appears.
- STAGES=4, Rst pulsed one cycle while 4 valid entries are in flight -> OutValid=0 for the next 4 cycles even with InValid low. A new input (IN=0x00FF, Mode=00) appears as 0x000000FF exactly 4 cycles after entry.
